seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: sysclk cycles each digit is lit (minimum 2).
REQ-002 SHALL have parameter DIV_BITS, default 16: scan counter width; must hold SCAN_DIV-1.
REQ-003 SHALL have port sysclk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  one-cycle write strobe from the CPU device controller.
REQ-006 SHALL have port wr_data  input  16  four hex nibbles; nibble k drives digit k (k=0 is least significant).
REQ-007 SHALL have port wr_dp  input  4  decimal point per digit, 1 = lit.
REQ-008 SHALL have port pending  output  1  shadow holds a value not yet shown.
REQ-009 SHALL have port digi  output  12  {an[3:0], dp, g, f, e, d, c, b, a}; all bits active-low.

Function
REQ-010 SHALL keep a shadow register (16+4 bits) and a display register (16+4 bits).
REQ-011 On wr_en, shadow SHALL load wr_data/wr_dp and pending SHALL set on the next edge.
REQ-012 Scan counter cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; digit index idx SHALL advance 0->1->2->3->0 on each cnt wrap.
REQ-013 Frame boundary = cnt wrap while idx==3; on it, if pending, display SHALL load shadow and pending SHALL clear.
REQ-014 wr_en coincident with a frame boundary SHALL win: shadow takes the new data, pending stays 1, display unchanged, transfer at the next boundary.
REQ-015 Consecutive wr_en before a boundary SHALL overwrite the shadow; only the last value is displayed.
REQ-016 digi SHALL be registered: one cycle after (idx, display) settle, an = one-hot-low of idx (idx0 -> 4'b1110).
REQ-017 Segment field SHALL be the standard hex decode of the selected nibble (0->0x40 gfedcba-low form; full field with dp off: 0->0xC0, 8->0x80, F->0x8E).
REQ-018 dp bit SHALL be low when display dp of the selected digit is 1.
REQ-019 Exactly one anode SHALL be low on every cycle after the first post-reset edge; no glitch cycle with two anodes low.

Reset
REQ-020 Reset low SHALL immediately force digi=12'hFFF, pending=0, cnt=0, idx=0, shadow=0, display=0.
REQ-021 Reset asserted mid-frame or with pending=1 SHALL discard the shadow; no transfer after release.
REQ-022 First edge after release SHALL give digi=12'hEC0 (digit 0 showing '0').

Configuration
REQ-023 Macro SEG_LEADING_ZERO_BLANK_EN SHALL select leading-zero blanking.
REQ-024 With macro defined: digit k (k>=1) SHALL show all segments off (g..a = 1) when display nibbles k..3 are all zero; digit 0 never blanked; anode and dp unaffected.
REQ-025 Without macro: all four digits SHALL always show their hex value.

Verification (SCAN_DIV=4)
REQ-026 Reset release, no writes -> digi=12'hEC0 for 4 cycles, then an steps 1101,1011,0111,1110 every 4 cycles; macro off: segments 0xC0 each; macro on: digits 1-3 segments 0xFF.
REQ-027 wr_en with 16'h12AF, dp=4'b0001 mid-frame -> pending=1 until the frame boundary, then digit 0 shows 0x0E (F, dp lit), digits 1-3 show A, 2, 1; pending=0.
REQ-028 wr_en pulsed exactly on the frame-boundary cycle -> display unchanged for that frame; new value appears at the following boundary.
REQ-029 Two writes 16'h1111 then 16'h2222 in one frame -> only 2222 is ever displayed.
REQ-030 reset pulled low while pending=1 mid-digit -> digi=12'hFFF asynchronously; after release the display shows 0000, pending=0.
REQ-031 Macro on, write 16'h0050 -> digit 3 blank, digit 2 blank, digit 1 shows '5', digit 0 shows '0'.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment scanner with a shadow/display double buffer.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is never blanked).
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int DIV_BITS = 16
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    output logic        pending,
    output logic [11:0] digi
);
    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [15:0]         shd_q, shd_d, disp_q, disp_d;
    logic [3:0]          sdp_q, sdp_d, ddp_q, ddp_d;
    logic                pend_q, pend_d;
    logic [11:0]         digi_q, digi_d;
    logic                wrap, frame, blank;
    logic [3:0]          nib;
    logic [6:0]          seg;

    always_comb begin
        wrap   = cnt_q == DIV_BITS'(SCAN_DIV - 1);
        frame  = wrap && idx_q == 2'd3;
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        idx_d  = wrap ? idx_q + 2'd1 : idx_q;
        shd_d  = wr_en ? wr_data : shd_q;
        sdp_d  = wr_en ? wr_dp : sdp_q;
        // A write landing on the frame boundary defers the transfer to the next frame
        pend_d = wr_en | (pend_q & ~frame);
        disp_d = (frame && pend_q && !wr_en) ? shd_q : disp_q;
        ddp_d  = (frame && pend_q && !wr_en) ? sdp_q : ddp_q;
        nib    = disp_q[{idx_q, 2'b00} +: 4];
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
`ifdef SEG_LEADING_ZERO_BLANK_EN
        blank  = idx_q != 2'd0 && (disp_q >> {idx_q, 2'b00}) == 16'd0;
`else
        blank  = 1'b0;
`endif
        digi_d = {~(4'b0001 << idx_q), ~ddp_q[idx_q], blank ? 7'h7F : seg};
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            shd_q  <= 16'd0;
            sdp_q  <= 4'd0;
            disp_q <= 16'd0;
            ddp_q  <= 4'd0;
            pend_q <= 1'b0;
            digi_q <= 12'hFFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            shd_q  <= shd_d;
            sdp_q  <= sdp_d;
            disp_q <= disp_d;
            ddp_q  <= ddp_d;
            pend_q <= pend_d;
            digi_q <= digi_d;
        end
    end

    assign pending = pend_q;
    assign digi    = digi_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: bench for seg_scan_ctrl at SCAN_DIV=4; expected frames come from hand-decoded tables.
// Expectations follow SEG_LEADING_ZERO_BLANK_EN when it is defined.
module tb_seg_scan_ctrl;
    typedef struct {
        logic [15:0] d;
        logic [3:0]  dp;
        logic [47:0] e;
        logic [47:0] eb;
    } vec_t;

    logic        sysclk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = 16'd0;
    logic [3:0]  wr_dp = 4'd0;
    logic        pending;
    logic [11:0] digi;
    int          checks = 0;
    int          errors = 0;
    logic        run = 1'b0;
    logic [11:0] sb[$];
    vec_t        tbl[6];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [47:0] ZF = {12'h7FF, 12'hBFF, 12'hDFF, 12'hEC0};
`else
    localparam logic [47:0] ZF = {12'h7C0, 12'hBC0, 12'hDC0, 12'hEC0};
`endif

    seg_scan_ctrl #(.SCAN_DIV(4), .DIV_BITS(16)) dut (
        .sysclk(sysclk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .wr_dp(wr_dp), .pending(pending), .digi(digi)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) if (run) begin
        checks++;
        if ($countones(~digi[11:8]) != 1) begin
            errors++;
            $display("FAIL one_anode got an=%b expected exactly one low", digi[11:8]);
        end
    end

    function automatic logic [47:0] pick(input vec_t v);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        return v.eb;
`else
        return v.e;
`endif
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic write(input logic [15:0] d, input logic [3:0] dp);
        wr_en = 1'b1; wr_data = d; wr_dp = dp;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push_frame(input logic [47:0] f);
        for (int k = 0; k < 4; k++) sb.push_back(f[k*12 +: 12]);
    endtask

    task automatic frame_start();
        logic [3:0] prev;
        logic found;
        found = 1'b0;
        prev = digi[11:8];
        for (int n = 0; n < 64 && !found; n++) begin
            tick();
            found = prev == 4'b0111 && digi[11:8] == 4'b1110;
            prev = digi[11:8];
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL frame_start timeout got an=%b expected 0111->1110", digi[11:8]);
        end
    endtask

    task automatic check_frame(input string name, input logic exp_pend);
        frame_start();
        check({name, "_pend"}, {11'd0, pending}, {11'd0, exp_pend});
        for (int k = 0; k < 4; k++) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s scoreboard empty got %h expected entry", name, digi);
            end else check($sformatf("%s_d%0d", name, k), digi, sb.pop_front());
            if (k < 3) repeat (4) tick();
        end
    endtask

    initial begin
        tbl[0] = '{16'h12AF, 4'b0001, {12'h7F9, 12'hBA4, 12'hD88, 12'hE0E}, {12'h7F9, 12'hBA4, 12'hD88, 12'hE0E}};
        tbl[1] = '{16'h0050, 4'b0000, {12'h7C0, 12'hBC0, 12'hD92, 12'hEC0}, {12'h7FF, 12'hBFF, 12'hD92, 12'hEC0}};
        tbl[2] = '{16'h8E3C, 4'b1010, {12'h700, 12'hB86, 12'hD30, 12'hEC6}, {12'h700, 12'hB86, 12'hD30, 12'hEC6}};
        tbl[3] = '{16'h0000, 4'b1111, {12'h740, 12'hB40, 12'hD40, 12'hE40}, {12'h77F, 12'hB7F, 12'hD7F, 12'hE40}};
        tbl[4] = '{16'h0B07, 4'b0100, {12'h7C0, 12'hB03, 12'hDC0, 12'hEF8}, {12'h7FF, 12'hB03, 12'hDC0, 12'hEF8}};
        tbl[5] = '{16'h9D46, 4'b0000, {12'h790, 12'hBA1, 12'hD99, 12'hE82}, {12'h790, 12'hBA1, 12'hD99, 12'hE82}};

        #12;
        check("rst_digi", digi, 12'hFFF);
        check("rst_pend", {11'd0, pending}, 12'd0);
        @(negedge sysclk) reset = 1'b1;
        tick();
        run = 1'b1;
        check("first_edge", digi, 12'hEC0);
        for (int c = 1; c < 4; c++) begin
            tick();
            check($sformatf("idle_d0_c%0d", c), digi, 12'hEC0);
        end
        for (int k = 1; k < 5; k++) begin
            tick();
            check($sformatf("idle_step%0d", k), digi, ZF[(k%4)*12 +: 12]);
            if (k < 4) repeat (3) tick();
        end

        for (int i = 0; i < 6; i++) begin
            frame_start();
            repeat (2) tick();
            write(tbl[i].d, tbl[i].dp);
            check($sformatf("vec%0d_pend_set", i), {11'd0, pending}, 12'd1);
            push_frame(pick(tbl[i]));
            check_frame($sformatf("vec%0d", i), 1'b0);
        end

        // write A mid-frame, then B on the boundary cycle: A is never shown, B a frame later
        frame_start();
        tick();
        write(tbl[0].d, tbl[0].dp);
        repeat (12) tick();
        write(tbl[1].d, tbl[1].dp);
        check("bnd_pend", {11'd0, pending}, 12'd1);
        push_frame(pick(tbl[5]));
        push_frame(pick(tbl[1]));
        check_frame("bnd_hold", 1'b1);
        check_frame("bnd_new", 1'b0);

        frame_start();
        tick();
        write(16'h1111, 4'b0000);
        tick();
        write(16'h2222, 4'b0000);
        push_frame({12'h7A4, 12'hBA4, 12'hDA4, 12'hEA4});
        check_frame("dbl_wr", 1'b0);

        frame_start();
        repeat (5) tick();
        write(tbl[5].d, tbl[5].dp);
        check("rst_mid_pend", {11'd0, pending}, 12'd1);
        #2;
        run = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_async_digi", digi, 12'hFFF);
        check("rst_async_pend", {11'd0, pending}, 12'd0);
        repeat (2) @(posedge sysclk);
        @(negedge sysclk) reset = 1'b1;
        tick();
        run = 1'b1;
        check("rst_rel_digi", digi, 12'hEC0);
        push_frame(ZF);
        check_frame("rst_zero", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
